_sipo_shift_reg: RTL and testbench
==================================

# _sipo_shift_reg

Serial-in/parallel-out shift register that sits directly upstream of the enabled-flip-flop register stage. It accumulates a serial bit stream under a shift enable and presents the completed parallel word together with a one-cycle `valid` pulse. The downstream `_dff_en` bank uses `valid` as its load enable. Each shift cell is built from `_dff_en` instances sharing the shift enable; the block adds the bit counter, the word-capture register and the `valid` strobe.

## Interface
- `WIDTH`, default 8: word length in bits; legal range is 2 to 32.
- `CW`, default `$clog2(WIDTH)`: bit-counter width (3 when WIDTH = 8).
- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  reset, synchronous, active-low. Sampled only at the rising edge of `clk`.
- `en`  input  1  shift enable. When high, `d_in` is sampled this edge.
- `d_in`  input  1  serial data, MSB first.
- `clr`  input  1  synchronous clear of the partial word.
- `q`  output  WIDTH  live shift-register contents.
- `word`  output  WIDTH  last completed word.
- `valid`  output  1  one-cycle pulse: `word` was updated this cycle.
- `cnt`  output  CW  bits received in the current word, 0 to WIDTH-1.

## Operation
- Priority at each rising edge: `reset_n` low, then `clr`, then `en`, then hold.
- Reset (`reset_n` = 0): `q`=0, `word`=0, `valid`=0, `cnt`=0.
- Clear (`clr` = 1):
  - `q`=0, `cnt`=0, `valid`=0.
  - `word` holds its value.
  - `en` is ignored this edge.
- Shift (`en` = 1):
  - `q` <= {q[WIDTH-2:0], d_in}.
  - If `cnt` < WIDTH-1: `cnt` <= `cnt`+1 and `valid` <= 0.
  - If `cnt` == WIDTH-1: `cnt` wraps to 0, `word` <= {q[WIDTH-2:0], d_in}, `valid` <= 1.
- Hold (`en` = 0): `q`, `cnt` and `word` are unchanged; `valid` <= 0.
- The first bit received ends up in `word[WIDTH-1]`.
- `q` is not cleared on word completion. The next word shifts over the old bits.
- Bit-cell structure:
  - The `q` bits are `_dff_en` cells with cell enable = `en | clr | ~reset_n`.
  - The cell data input is forced to 0 when `clr` or `~reset_n` is active.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Each `en` edge adds one bit; there is no minimum gap between bits.
- Word latency:
  - `word` and `valid` change at the same edge that samples bit WIDTH.
  - Both are visible in the following cycle.
  - `valid` drops at the next edge.
- Back-to-back: WIDTH consecutive `en` cycles produce `valid` pulses exactly WIDTH cycles apart, with no lost bit.
- Gaps in `en` stretch the word; the count resumes where it stopped.
- `clr` and `en` both high on the final bit: the clear wins, no `valid`, `word` is unchanged.
- `reset_n` low mid-word: the partial word is discarded and everything returns to the reset values at that edge. `word` is not preserved.
- `valid` is never high for two consecutive cycles, because WIDTH ≥ 2.

## Test plan
- Reset: hold `reset_n`=0 for 2 edges with `en`=1 and `d_in`=1 -> `q`=0, `word`=0, `valid`=0, `cnt`=0.
- Single word, WIDTH=8: shift 1,0,1,1,0,0,1,0 on 8 consecutive edges -> `cnt` counts 1..7 then 0; `word`=8'hB2 with `valid`=1 for one cycle after the 8th edge; `valid`=0 otherwise.
- Gapped enable: the same 8 bits with `en` low for 3 cycles after bit 4 -> `cnt` holds at 4 through the gap; `word`=8'hB2; `valid` pulses once, 3 cycles later than in the gapless case.
- Clear mid-word: 3 bits, then `clr`, then 8 bits of 8'h3C -> `cnt`=0 after the clear; `word` keeps its previous value until 8'h3C arrives with a single `valid`.
- Back-to-back: 16 consecutive bits forming 8'hA5 then 8'h3C -> two `valid` pulses 8 cycles apart carrying 8'hA5 and 8'h3C; then `clr`=`en`=1 on the 8th bit of a third word -> no `valid`, `word` stays 8'h3C.
- Reset mid-word: 5 bits, then `reset_n`=0 for 1 edge -> all outputs 0, including `word`; the next 8 bits of 8'hFF give `word`=8'hFF.

Source files
------------

// File: rtl/_sipo_shift_reg.sv
// ---------------------------------------------------------------------------
// _sipo_shift_reg
//
// Serial-in / parallel-out shift register. Bits arrive MSB first on d_in
// while en is high. After WIDTH bits, the completed word is copied into the
// word register, and valid pulses for one cycle. The downstream register bank
// uses valid as its load enable.
//
// The live shift register q is built from 1-bit _dff_en cells. Their cell
// enable is (en | clr | ~reset_n). Their data input is forced to 0 whenever
// clr or reset is active, so reset and clear reuse the plain enabled cell.
//
// Ports
//   clk      in   1      rising-edge clock
//   reset_n  in   1      synchronous active-low reset
//   en       in   1      shift enable; d_in is sampled when high
//   d_in     in   1      serial data, MSB first
//   clr      in   1      synchronous clear of the partial word (word kept)
//   q        out  WIDTH  live shift-register contents
//   word     out  WIDTH  last completed word
//   valid    out  1      one-cycle pulse: word was updated at the last edge
//   cnt      out  CW     bits received in the current word, 0..WIDTH-1
//
// Handshake: valid is a push-only strobe with no ready. It is high for
// exactly the one cycle after word is loaded, and the consumer must take word
// on that cycle. word then holds until the next completion or reset.
// Priority at every edge: reset_n low, then clr, then en, then hold.
// ---------------------------------------------------------------------------

// 1-bit enabled flip-flop used as the shift cell.
//   clk in 1, en in 1, d in 1, q out 1
module _dff_en (
    input  logic clk,
    input  logic en,
    input  logic d,
    output logic q
);
    logic r_q;

    always_ff @(posedge clk) begin
        if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;
endmodule

module _sipo_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             d_in,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] word,
    output logic             valid,
    output logic [CW-1:0]    cnt
);
    localparam logic [CW-1:0] LP_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_word;
    logic             r_valid;
    logic [CW-1:0]    r_cnt;

    logic             w_cell_en;
    logic             w_force0;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_cell_d;

    // Reset and clear must also reach the cells, so they join the enable.
    assign w_cell_en = en | clr | ~reset_n;
    assign w_force0  = clr | ~reset_n;
    assign w_shift   = {r_q[WIDTH-2:0], d_in};
    assign w_cell_d  = w_force0 ? '0 : w_shift;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        _dff_en u_cell (
            .clk (clk),
            .en  (w_cell_en),
            .d   (w_cell_d[gi]),
            .q   (r_q[gi])
        );
    end

    // Counter, word capture and strobe.
    // The word is captured from the same shifted value that the cells load,
    // so word equals q right after the final bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else if (clr) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (en) begin
            if (r_cnt == LP_LAST) begin
                r_cnt   <= '0;
                r_word  <= w_shift;
                r_valid <= 1'b1;
            end else begin
                r_cnt   <= r_cnt + CW'(1);
                r_valid <= 1'b0;
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign q     = r_q;
    assign word  = r_word;
    assign valid = r_valid;
    assign cnt   = r_cnt;
endmodule

// File: tb/tb__sipo_shift_reg.sv
// ---------------------------------------------------------------------------
// Testbench for _sipo_shift_reg (WIDTH = 8).
// A reference model tracks q/word/valid/cnt and pushes each expected
// completed word into exp_q. A monitor pops exp_q on every valid pulse.
// ---------------------------------------------------------------------------
module tb__sipo_shift_reg;
    localparam int W  = 8;
    localparam int CW = 3;

    logic          clk;
    logic          reset_n;
    logic          en;
    logic          d_in;
    logic          clr;
    logic [W-1:0]  q;
    logic [W-1:0]  word;
    logic          valid;
    logic [CW-1:0] cnt;

    int n_cmp;
    int n_err;
    int n_valid;

    logic [W-1:0]  exp_q[$];

    // Reference model state.
    logic [W-1:0]  m_q;
    logic [W-1:0]  m_word;
    logic          m_valid;
    logic [CW-1:0] m_cnt;

    _sipo_shift_reg #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .d_in    (d_in),
        .clr     (clr),
        .q       (q),
        .word    (word),
        .valid   (valid),
        .cnt     (cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver ----------------
    // Apply one edge of stimulus, then advance the model. Outputs are
    // observed 1 time unit after the edge.
    task automatic drive(input logic e, input logic d, input logic c, input logic r);
        en      = e;
        d_in    = d;
        clr     = c;
        reset_n = r;
        @(posedge clk);
        #1;
        if (!r) begin
            m_q = '0; m_word = '0; m_valid = 1'b0; m_cnt = '0;
        end else if (c) begin
            m_q = '0; m_valid = 1'b0; m_cnt = '0;
        end else if (e) begin
            m_q = {m_q[W-2:0], d};
            if (m_cnt == CW'(W - 1)) begin
                m_cnt   = '0;
                m_word  = m_q;
                m_valid = 1'b1;
                exp_q.push_back(m_q);
            end else begin
                m_cnt   = m_cnt + CW'(1);
                m_valid = 1'b0;
            end
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic shift_word(input logic [W-1:0] pat);
        for (int i = W - 1; i >= 0; i--) drive(1'b1, pat[i], 1'b0, 1'b1);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            n_valid++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_valid: word=%h, required no valid", word);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (word !== e) begin
                    n_err++;
                    $display("FAIL sb_word: got %h, required %h", word, e);
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (q !== 8'h00)     begin n_err++; $display("FAIL reset_q: got %h, required 00", q); end
        n_cmp++; if (word !== 8'h00)  begin n_err++; $display("FAIL reset_word: got %h, required 00", word); end
        n_cmp++; if (valid !== 1'b0)  begin n_err++; $display("FAIL reset_valid: got %b, required 0", valid); end
        n_cmp++; if (cnt !== 3'd0)    begin n_err++; $display("FAIL reset_cnt: got %0d, required 0", cnt); end
    endtask

    task automatic test_single_word();
        logic [W-1:0] pat;
        int v0;
        pat = 8'hB2;
        v0  = n_valid;
        for (int i = W - 1; i >= 0; i--) begin
            drive(1'b1, pat[i], 1'b0, 1'b1);
            n_cmp++;
            if (cnt !== CW'(W - i)) begin
                n_err++; $display("FAIL single_cnt: got %0d, required %0d", cnt, CW'(W - i));
            end
            n_cmp++;
            if (valid !== (i == 0)) begin
                n_err++; $display("FAIL single_valid: got %b, required %b", valid, (i == 0));
            end
        end
        n_cmp++; if (word !== 8'hB2) begin n_err++; $display("FAIL single_word: got %h, required b2", word); end
        n_cmp++; if (q !== 8'hB2)    begin n_err++; $display("FAIL single_q: got %h, required b2", q); end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL single_valid_drop: got %b, required 0", valid); end
        n_cmp++; if (n_valid - v0 != 1) begin n_err++; $display("FAIL single_pulses: got %0d, required 1", n_valid - v0); end
    endtask

    task automatic test_gapped();
        logic [W-1:0] pat;
        int v0;
        int gap_cycle;
        int pulse_cycle;
        pat = 8'hB2;
        v0  = n_valid;
        gap_cycle = 0;
        pulse_cycle = -1;
        for (int i = W - 1; i >= 4; i--) drive(1'b1, pat[i], 1'b0, 1'b1);
        for (int g = 0; g < 3; g++) begin
            drive(1'b0, $urandom_range(0, 1), 1'b0, 1'b1);
            n_cmp++;
            if (cnt !== 3'd4 || valid !== 1'b0) begin
                n_err++; $display("FAIL gap_hold: cnt=%0d valid=%b, required cnt=4 valid=0", cnt, valid);
            end
        end
        for (int i = 3; i >= 0; i--) begin
            drive(1'b1, pat[i], 1'b0, 1'b1);
            gap_cycle++;
            if (valid === 1'b1) pulse_cycle = gap_cycle;
        end
        n_cmp++; if (pulse_cycle != 4) begin n_err++; $display("FAIL gap_pulse_pos: got %0d, required 4", pulse_cycle); end
        n_cmp++; if (word !== 8'hB2)   begin n_err++; $display("FAIL gap_word: got %h, required b2", word); end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (n_valid - v0 != 1) begin n_err++; $display("FAIL gap_pulses: got %0d, required 1", n_valid - v0); end
    endtask

    task automatic test_clear_mid();
        logic [W-1:0] pat;
        pat = 8'h3C;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (cnt !== 3'd0)   begin n_err++; $display("FAIL clr_cnt: got %0d, required 0", cnt); end
        n_cmp++; if (q !== 8'h00)    begin n_err++; $display("FAIL clr_q: got %h, required 00", q); end
        n_cmp++; if (word !== 8'hB2) begin n_err++; $display("FAIL clr_word_hold: got %h, required b2", word); end
        for (int i = W - 1; i >= 0; i--) begin
            drive(1'b1, pat[i], 1'b0, 1'b1);
            if (i != 0) begin
                n_cmp++;
                if (word !== 8'hB2) begin n_err++; $display("FAIL clr_word_early: got %h, required b2", word); end
            end
        end
        n_cmp++; if (word !== 8'h3C || valid !== 1'b1) begin
            n_err++; $display("FAIL clr_new_word: word=%h valid=%b, required 3c/1", word, valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] pat;
        int first;
        int second;
        first  = -1;
        second = -1;
        pat = 16'hA53C;
        for (int i = 2 * W - 1; i >= 0; i--) begin
            drive(1'b1, pat[i], 1'b0, 1'b1);
            if (valid === 1'b1) begin
                if (first < 0) first = 2 * W - i; else second = 2 * W - i;
            end
            n_cmp++;
            if (cnt !== m_cnt) begin n_err++; $display("FAIL b2b_cnt: got %0d, required %0d", cnt, m_cnt); end
        end
        n_cmp++; if (first != 8 || second != 16) begin
            n_err++; $display("FAIL b2b_spacing: pulses at %0d,%0d, required 8,16", first, second);
        end
        // Third word: clear collides with the final bit.
        for (int i = 0; i < W - 1; i++) drive(1'b1, $urandom_range(0, 1), 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL b2b_clr_valid: got %b, required 0", valid); end
        n_cmp++; if (word !== 8'h3C) begin n_err++; $display("FAIL b2b_clr_word: got %h, required 3c", word); end
        n_cmp++; if (cnt !== 3'd0)   begin n_err++; $display("FAIL b2b_clr_cnt: got %0d, required 0", cnt); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (q !== 8'h00 || word !== 8'h00 || valid !== 1'b0 || cnt !== 3'd0) begin
            n_err++; $display("FAIL rstmid_all: q=%h word=%h valid=%b cnt=%0d, required all 0", q, word, valid, cnt);
        end
        shift_word(8'hFF);
        n_cmp++; if (word !== 8'hFF || valid !== 1'b1) begin
            n_err++; $display("FAIL rstmid_word: word=%h valid=%b, required ff/1", word, valid);
        end
        n_cmp++; if (word !== m_word || q !== m_q) begin
            n_err++; $display("FAIL rstmid_model: word=%h q=%h, required %h/%h", word, q, m_word, m_q);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_cmp = 0; n_err = 0; n_valid = 0;
        m_q = '0; m_word = '0; m_valid = 1'b0; m_cnt = '0;
        reset_n = 1'b0; en = 1'b0; d_in = 1'b0; clr = 1'b0;
        test_reset();
        test_single_word();
        test_gapped();
        test_clear_mid();
        test_back_to_back();
        test_reset_mid();
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL sb_leftover: %0d words pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
